edge_sobel_pipe: RTL and testbench

Parametrised streaming Sobel edge detector for the ZBT video path. Each cycle it takes one RGB pixel from a two-pixel ZBT word, converts it to grayscale, builds a 3x3 window from two internal line buffers, and outputs gradient magnitude, thresholded edges, grayscale passthrough or an edge-over-gray overlay as 24-bit RGB. It sits between the ZBT read mux and the VGA output select mux, and drives that mux's `select`.

---
 rtl/edge_pkg.sv | 25 ++
 rtl/line_window.sv | 77 +++++++
 rtl/edge_sobel_pipe.sv | 202 ++++++++++++++++++++
 tb/tb_edge_sobel_pipe.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/edge_pkg.sv
// Shared types and constants for the Sobel edge pipeline on the ZBT-to-VGA path.
package edge_pkg;

  typedef enum logic [1:0] {
    MODE_GRAY = 2'b00,
    MODE_MAG  = 2'b01,
    MODE_BIN  = 2'b10,
    MODE_OVL  = 2'b11
  } mode_e;

  localparam int unsigned LUMA_R = 77;
  localparam int unsigned LUMA_G = 150;
  localparam int unsigned LUMA_B = 29;

  localparam int PIX_W_DEF = 8;
  localparam int EDGE_LAT  = 4;

  // Weights sum to 256, so the 16-bit accumulator never overflows for 8-bit channels.
  function automatic logic [15:0] luma(input logic [23:0] px);
    return 16'(px[23:16]) * 16'(LUMA_R)
         + 16'(px[15:8])  * 16'(LUMA_G)
         + 16'(px[7:0])   * 16'(LUMA_B);
  endfunction

endpackage

// File: rtl/line_window.sv
// Two line buffers plus the 3x3 sliding window; row 0 of the taps is the oldest line.
module line_window
  import edge_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int COLS  = 1024,
  parameter int AW    = $clog2(COLS)
)(
  input  logic             clock,
  input  logic             reset,
  input  logic             pix_valid,
  input  logic             pix_we,
  input  logic [PIX_W-1:0] pix,
  input  logic [AW-1:0]    col,
  output logic [PIX_W-1:0] t00,
  output logic [PIX_W-1:0] t01,
  output logic [PIX_W-1:0] t02,
  output logic [PIX_W-1:0] t10,
  output logic [PIX_W-1:0] t11,
  output logic [PIX_W-1:0] t12,
  output logic [PIX_W-1:0] t20,
  output logic [PIX_W-1:0] t21,
  output logic [PIX_W-1:0] t22,
  output logic             win_valid
);

  logic [PIX_W-1:0] lb1 [COLS];
  logic [PIX_W-1:0] lb2 [COLS];
  logic [PIX_W-1:0] rd1, rd2;
  logic [PIX_W-1:0] w_top [3];
  logic [PIX_W-1:0] w_mid [3];
  logic [PIX_W-1:0] w_bot [3];

  assign rd1 = lb1[col];
  assign rd2 = lb2[col];

  // Read-before-write: lb1 holds line r-1, and its old word cascades into lb2 as line r-2.
  always_ff @(posedge clock) begin
    if (pix_we) begin
      lb1[col] <= pix;
      lb2[col] <= rd1;
    end
  end

  always_ff @(posedge clock) begin
    if (pix_we) begin
      w_top[0] <= w_top[1];
      w_top[1] <= w_top[2];
      w_top[2] <= rd2;
      w_mid[0] <= w_mid[1];
      w_mid[1] <= w_mid[2];
      w_mid[2] <= rd1;
      w_bot[0] <= w_bot[1];
      w_bot[1] <= w_bot[2];
      w_bot[2] <= pix;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      win_valid <= 1'b0;
    end else begin
      win_valid <= pix_valid;
    end
  end

  assign t00 = w_top[0];
  assign t01 = w_top[1];
  assign t02 = w_top[2];
  assign t10 = w_mid[0];
  assign t11 = w_mid[1];
  assign t12 = w_mid[2];
  assign t20 = w_bot[0];
  assign t21 = w_bot[1];
  assign t22 = w_bot[2];

endmodule

// File: rtl/edge_sobel_pipe.sv
// Streaming 4-stage Sobel edge detector: gray, window, gradients, magnitude/mode.
// Define EDGE_OVERLAY_EN to enable the red-on-gray overlay for mode 11.
module edge_sobel_pipe
  import edge_pkg::*;
#(
  parameter int               PIX_W      = PIX_W_DEF,
  parameter int               COLS       = 1024,
  parameter logic [PIX_W-1:0] THRESH_RST = PIX_W'(64)
)(
  input  logic             clock,
  input  logic             reset,
  input  logic [23:0]      rgb,
  input  logic [23:0]      rgb1,
  input  logic [10:0]      hcount,
  input  logic             in_valid,
  input  logic             line_start,
  input  logic             frame_start,
  input  logic [1:0]       mode,
  input  logic             thresh_we,
  input  logic [PIX_W-1:0] thresh_in,
  output logic [23:0]      edgeoutputsel,
  output logic             out_valid,
  output logic             select
);

  localparam int AW = $clog2(COLS);
  localparam int SW = PIX_W + 3;
  localparam logic [AW-1:0] COL_LAST = AW'(COLS - 1);

  function automatic logic signed [SW-1:0] sx(input logic [PIX_W-1:0] p);
    return signed'(SW'(p));
  endfunction

  logic unused_hcount;
  assign unused_hcount = ^hcount[10:1];

  // Stage 1: pixel mux, luma and position tracking
  logic [23:0]      px_in;
  logic [15:0]      luma_acc;
  logic [PIX_W-1:0] y_in;

  assign px_in    = hcount[0] ? rgb : rgb1;
  assign luma_acc = luma(px_in);
  assign y_in     = PIX_W'(luma_acc >> 8);

  logic [1:0]    row_q, nxt_row;
  logic [AW-1:0] col_q, nxt_col;
  logic          ovf_q, nxt_ovf;
  logic          sync_q, nxt_sync;
  logic          bord_in;

  // Rows only advance once a frame_start has been seen since reset.
  always_comb begin
    nxt_row  = row_q;
    nxt_col  = col_q;
    nxt_ovf  = ovf_q;
    nxt_sync = sync_q;
    if (frame_start) begin
      nxt_row  = '0;
      nxt_col  = '0;
      nxt_ovf  = 1'b0;
      nxt_sync = 1'b1;
    end else if (line_start) begin
      nxt_col = '0;
      nxt_ovf = 1'b0;
      if (sync_q && row_q != 2'd3) nxt_row = row_q + 2'd1;
    end else if (col_q == COL_LAST) begin
      nxt_ovf = 1'b1;
    end else begin
      nxt_col = col_q + AW'(1);
    end
  end

  assign bord_in = (nxt_row < 2'd2) || (nxt_col < AW'(2)) || nxt_ovf;

  logic                  v1, we1;
  logic [PIX_W-1:0]      y1;
  logic [AW-1:0]         col1;
  logic [EDGE_LAT-2:0]   bord_sr;

  always_ff @(posedge clock) begin
    if (!reset) begin
      row_q   <= '0;
      col_q   <= '0;
      ovf_q   <= 1'b0;
      sync_q  <= 1'b0;
      v1      <= 1'b0;
      we1     <= 1'b0;
      bord_sr <= '1;
    end else begin
      v1  <= in_valid;
      we1 <= in_valid && !nxt_ovf;
      if (in_valid) begin
        row_q  <= nxt_row;
        col_q  <= nxt_col;
        ovf_q  <= nxt_ovf;
        sync_q <= nxt_sync;
      end
      bord_sr[0] <= bord_in;
      for (int unsigned i = 1; i < EDGE_LAT - 1; i++) bord_sr[i] <= bord_sr[i-1];
    end
  end

  always_ff @(posedge clock) begin
    y1   <= y_in;
    col1 <= nxt_col;
  end

  // Stage 2: line buffers and window
  logic [PIX_W-1:0] t00, t01, t02, t10, t11, t12, t20, t21, t22;
  logic             win_valid;

  line_window #(
    .PIX_W (PIX_W),
    .COLS  (COLS),
    .AW    (AW)
  ) u_window (
    .clock     (clock),
    .reset     (reset),
    .pix_valid (v1),
    .pix_we    (we1),
    .pix       (y1),
    .col       (col1),
    .t00       (t00),
    .t01       (t01),
    .t02       (t02),
    .t10       (t10),
    .t11       (t11),
    .t12       (t12),
    .t20       (t20),
    .t21       (t21),
    .t22       (t22),
    .win_valid (win_valid)
  );

  // Stage 3: gradients
  logic signed [SW-1:0] gx_c, gy_c, gx3, gy3;
  logic [PIX_W-1:0]     y3;
  logic                 v3;

  assign gx_c = (sx(t02) + (sx(t12) <<< 1) + sx(t22)) - (sx(t00) + (sx(t10) <<< 1) + sx(t20));
  assign gy_c = (sx(t20) + (sx(t21) <<< 1) + sx(t22)) - (sx(t00) + (sx(t01) <<< 1) + sx(t02));

  always_ff @(posedge clock) begin
    if (!reset) begin
      v3 <= 1'b0;
    end else begin
      v3 <= win_valid;
    end
  end

  always_ff @(posedge clock) begin
    gx3 <= gx_c;
    gy3 <= gy_c;
    y3  <= t11;
  end

  // Stage 4: magnitude, threshold and mode select
  logic [PIX_W-1:0] thresh_q;
  logic [SW-1:0]    ax, ay, mag_sum;
  logic [PIX_W-1:0] mag, v;
  logic             hit;
  logic [23:0]      pix_c;
  mode_e            mode_s;

  assign mode_s  = mode_e'(mode);
  assign ax      = gx3[SW-1] ? $unsigned(-gx3) : $unsigned(gx3);
  assign ay      = gy3[SW-1] ? $unsigned(-gy3) : $unsigned(gy3);
  assign mag_sum = ax + ay;
  assign mag     = (mag_sum[SW-1:PIX_W] != '0) ? '1 : mag_sum[PIX_W-1:0];
  assign hit     = mag >= thresh_q;

  always_comb begin
    v     = '0;
    pix_c = '0;
    case (mode_s)
      MODE_GRAY: v = y3;
      MODE_MAG:  v = mag;
      MODE_BIN:  v = hit ? '1 : '0;
      MODE_OVL:  v = hit ? '1 : '0;
    endcase
    pix_c = {3{8'(v)}};
`ifdef EDGE_OVERLAY_EN
    if (mode_s == MODE_OVL) pix_c = hit ? {8'({PIX_W{1'b1}}), 16'h0000} : {3{8'(y3)}};
`endif
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      thresh_q      <= THRESH_RST;
      out_valid     <= 1'b0;
      select        <= 1'b0;
      edgeoutputsel <= '0;
    end else begin
      if (thresh_we) thresh_q <= thresh_in;
      out_valid     <= v3;
      select        <= v3 && (mode_s != MODE_GRAY);
      edgeoutputsel <= (v3 && !bord_sr[EDGE_LAT-2]) ? pix_c : '0;
    end
  end

endmodule

// File: tb/tb_edge_sobel_pipe.sv
// Directed bench for edge_sobel_pipe built with a 16-column line; covers both EDGE_OVERLAY_EN builds.
module tb_edge_sobel_pipe;

  localparam int COLSP = 16;
  localparam int NC    = 18;

  logic        clock = 1'b0;
  logic        reset;
  logic [23:0] rgb, rgb1;
  logic [10:0] hcount;
  logic        in_valid, line_start, frame_start;
  logic [1:0]  mode;
  logic        thresh_we;
  logic [7:0]  thresh_in;
  logic [23:0] edgeoutputsel;
  logic        out_valid, select;

  typedef struct packed {
    logic        v;
    logic        s;
    logic [23:0] p;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] thr = 8'd64;

  edge_sobel_pipe #(
    .PIX_W      (8),
    .COLS       (COLSP),
    .THRESH_RST (8'd64)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .rgb           (rgb),
    .rgb1          (rgb1),
    .hcount        (hcount),
    .in_valid      (in_valid),
    .line_start    (line_start),
    .frame_start   (frame_start),
    .mode          (mode),
    .thresh_we     (thresh_we),
    .thresh_in     (thresh_in),
    .edgeoutputsel (edgeoutputsel),
    .out_valid     (out_valid),
    .select        (select)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [23:0] expect_pix(input int r, input int c, input logic [7:0] lo,
                                             input logic [7:0] hi, input logic alt,
                                             input logic [1:0] m, input logic [7:0] th);
    int         diff, mag;
    logic [7:0] y;
    logic       hit;
    if (r < 2 || c < 2 || c >= COLSP) return 24'h000000;
    if (alt) return ((c - 1) % 2 == 1) ? 24'hFFFFFF : 24'h000000;
    diff = (hi > lo) ? int'(hi) - int'(lo) : int'(lo) - int'(hi);
    mag  = (c == 10 || c == 11) ? 4 * diff : 0;
    if (mag > 255) mag = 255;
    y    = (c - 1 < 10) ? lo : hi;
    hit  = mag >= int'(th);
    case (m)
      2'b00:   return {3{y}};
      2'b01:   return {3{8'(mag)}};
      2'b10:   return hit ? 24'hFFFFFF : 24'h000000;
      default: begin
`ifdef EDGE_OVERLAY_EN
        return hit ? 24'hFF0000 : {3{y}};
`else
        return hit ? 24'hFFFFFF : 24'h000000;
`endif
      end
    endcase
  endfunction

  // Drive one cycle, then compare whatever entered the pipe four edges ago.
  task automatic step(input logic [23:0] a, input logic [23:0] b, input logic hc0, input logic v,
                      input logic fs, input logic ls, input logic [23:0] ep);
    exp_t e;
    rgb = a; rgb1 = b; hcount = {10'd0, hc0};
    in_valid = v; frame_start = fs; line_start = ls;
    e.v = v;
    e.s = v && (mode != 2'b00);
    e.p = ep;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    if (exp_q.size() == 4) begin
      e = exp_q.pop_front();
      chk("out_valid", {23'd0, out_valid}, {23'd0, e.v});
      chk("select", {23'd0, select}, {23'd0, e.s});
      if (e.v) chk("pixel", edgeoutputsel, e.p);
    end
  endtask

  task automatic flush();
    repeat (4) step(24'h0, 24'h0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
  endtask

  task automatic load_thresh(input logic [7:0] t);
    thresh_in = t;
    thresh_we = 1'b1;
    step(24'h0, 24'h0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
    thresh_we = 1'b0;
    thr = t;
  endtask

  // fs_mode: 0 = no frame_start (row never advances), 1 = normal, 2 = frame_start with line_start.
  task automatic run_frame(input int nrows, input int fs_mode, input logic [7:0] lo,
                           input logic [7:0] hi, input logic alt, input int stop_after);
    int          n;
    logic [7:0]  g;
    logic [23:0] a, b, ep;
    logic        hc0, fs, ls;
    n = 0;
    for (int r = 0; r < nrows; r++) begin
      for (int c = 0; c < NC; c++) begin
        if (stop_after > 0 && n == stop_after) return;
        fs = (r == 0 && c == 0 && fs_mode != 0);
        ls = (c == 0) && (r > 0 || fs_mode != 1);
        if (alt) begin
          a = 24'hFFFFFF; b = 24'h000000; hc0 = (c % 2 == 1);
        end else begin
          g = (c < 10) ? lo : hi;
          a = {g, g, g}; b = 24'h5A3C96; hc0 = 1'b1;
        end
        ep = expect_pix((fs_mode == 0) ? 0 : r, c, lo, hi, alt, mode, thr);
        step(a, b, hc0, 1'b1, fs, ls, ep);
        n++;
      end
    end
  endtask

  initial begin
    reset = 1'b0; rgb = '0; rgb1 = '0; hcount = '0; in_valid = 1'b0;
    line_start = 1'b0; frame_start = 1'b0; mode = 2'b01; thresh_we = 1'b0; thresh_in = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_out_valid", {23'd0, out_valid}, 24'd0);
    chk("rst_select", {23'd0, select}, 24'd0);
    chk("rst_pixel", edgeoutputsel, 24'h000000);
    reset = 1'b1;

    mode = 2'b01;
    run_frame(5, 1, 8'd128, 8'd128, 1'b0, 0);
    flush();
    run_frame(4, 1, 8'd0, 8'd255, 1'b0, 0);
    flush();

    mode = 2'b10;
    run_frame(3, 1, 8'd0, 8'd20, 1'b0, 0);
    flush();
    load_thresh(8'd100);
    run_frame(3, 1, 8'd0, 8'd20, 1'b0, 0);
    flush();
    run_frame(3, 1, 8'd0, 8'd30, 1'b0, 0);
    flush();
    load_thresh(8'd130);
    run_frame(3, 1, 8'd0, 8'd30, 1'b0, 0);
    flush();

    mode = 2'b11;
    run_frame(3, 1, 8'd0, 8'd255, 1'b0, 0);
    flush();

    mode = 2'b00;
    run_frame(3, 1, 8'd0, 8'd0, 1'b1, 0);
    flush();

    mode = 2'b01;
    run_frame(4, 1, 8'd0, 8'd255, 1'b0, 2 * NC + 12);
    reset = 1'b0;
    in_valid = 1'b0; frame_start = 1'b0; line_start = 1'b0;
    @(posedge clock);
    #1;
    chk("midrst_out_valid", {23'd0, out_valid}, 24'd0);
    chk("midrst_select", {23'd0, select}, 24'd0);
    chk("midrst_pixel", edgeoutputsel, 24'h000000);
    reset = 1'b1;
    exp_q.delete();
    thr = 8'd64;
    run_frame(3, 0, 8'd0, 8'd255, 1'b0, 0);
    run_frame(3, 2, 8'd0, 8'd255, 1'b0, 0);
    flush();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
